// File: rtl/stage_memory_pkg.sv
// stage_memory_pkg: opcode constants, handshake state encoding and opcode class helpers
package stage_memory_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        return op == OP_RTYPE || op == OP_ADDI;
    endfunction

    function automatic logic is_mem_op(input logic [4:0] op);
        return op == OP_LW || op == OP_SW;
    endfunction

endpackage

// File: rtl/stage_memory_if.sv
// stage_memory_if: data-memory request/response bus between the memory stage and the memory
interface stage_memory_if #(
    parameter int ADDR_WIDTH = 12
);

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  ready;
    logic [31:0]           rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/stage_memory_fsm.sv
// dmem_handshake_fsm: IDLE/BUSY data-memory handshake; MEM_TIMEOUT_EN adds a wait counter with abort
module dmem_handshake_fsm
    import stage_memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic dmem_ready,
    output logic busy,
    output logic done,
    output logic abort,
    output logic mem_error
);

    state_t state, state_nx;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // count unanswered BUSY cycles; the abort decision is registered as the mem_error pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            wait_cnt  <= (busy && !dmem_ready && !abort) ? wait_cnt + 1'b1 : '0;
            mem_error <= abort;
        end
    end

    assign abort = busy && !dmem_ready && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort          = 1'b0;
    assign mem_error      = 1'b0;
`endif

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // outputs and next state: leave BUSY on the first ready cycle or on abort
    always_comb begin
        busy     = state == BUSY;
        done     = busy && dmem_ready;
        state_nx = state;
        if (state == IDLE && start)
            state_nx = BUSY;
        else if (state == BUSY && (done || abort))
            state_nx = IDLE;
    end

endmodule

// File: rtl/stage_memory.sv
// stage_memory: pipeline memory stage with dmem handshake and writeback register; MEM_TIMEOUT_EN enables BUSY timeout
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [4:0]           opcode,
    input  logic [31:0]          ALU_result,
    input  logic [31:0]          store_data,
    input  logic [4:0]           rd,
    output logic                 stall,
    stage_memory_if.master       dmem,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [4:0]           wb_rd,
    output logic [31:0]          wb_data,
    output logic                 mem_error
);

    logic                  accept;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [4:0]            rd_q;
    logic                  lw_q;

    assign accept = in_valid && !busy;
    assign start  = accept && is_mem_op(opcode);

    dmem_handshake_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dmem_ready(dmem.ready),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .mem_error (mem_error)
    );

    // capture the memory operation on its accept edge so the bus stays stable while BUSY
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            lw_q    <= 1'b0;
        end else if (start) begin
            addr_q  <= ALU_result[ADDR_WIDTH-1:0];
            wdata_q <= store_data;
            rd_q    <= rd;
            lw_q    <= opcode == OP_LW;
        end
    end

    assign stall      = busy;
    assign dmem.req   = busy;
    assign dmem.we    = busy && !lw_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    // writeback register: memory completions and aborts retire here, otherwise accepted non-memory ops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else if (done || abort) begin
            wb_valid <= 1'b1;
            wb_we    <= done && lw_q && rd_q != 5'd0;
            wb_rd    <= rd_q;
            if (done && lw_q)
                wb_data <= dmem.rdata;
        end else if (accept && !is_mem_op(opcode)) begin
            wb_valid <= 1'b1;
            wb_we    <= is_alu_op(opcode) && rd != 5'd0;
            wb_rd    <= rd;
            wb_data  <= ALU_result;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: scoreboard bench with a memory responder and a reference memory model
module tb_stage_memory;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_error;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fixed_lat = -1;
    logic [31:0] ref_mem [logic [11:0]];
    logic [31:0] mem [logic [11:0]];

    stage_memory_if #(.ADDR_WIDTH(12)) dmem_bus ();

    stage_memory #(
        .ADDR_WIDTH    (12),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .ALU_result(alu_result),
        .store_data(store_data),
        .rd        (rd),
        .stall     (stall),
        .dmem      (dmem_bus),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .mem_error (mem_error)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return 32'hC0DE_0000 ^ {a, a, a[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_stall"},     32'(stall), 0);
        check({p, "_req"},       32'(dmem_bus.req), 0);
        check({p, "_we"},        32'(dmem_bus.we), 0);
        check({p, "_wb_valid"},  32'(wb_valid), 0);
        check({p, "_wb_we"},     32'(wb_we), 0);
        check({p, "_wb_rd"},     32'(wb_rd), 0);
        check({p, "_wb_data"},   wb_data, 0);
        check({p, "_addr"},      32'(dmem_bus.addr), 0);
        check({p, "_wdata"},     dmem_bus.wdata, 0);
        check({p, "_mem_error"}, 32'(mem_error), 0);
    endtask

    // present one instruction, wait until it is accepted and record its expected retirement
    task automatic issue(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] r, input bit tmo);
        exp_t        e;
        logic [11:0] a;
        int          n;
        @(negedge clock);
        in_valid = 1'b1;
        opcode = op;
        alu_result = alu;
        store_data = sd;
        rd = r;
        n = 0;
        while (stall && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (stall) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_wait: stall still %b after %0d cycles, want 0", stall, n);
        end
        a = alu[11:0];
        e.rd = r;
        e.err = tmo;
        e.data = alu;
        e.chk_data = 1'b1;
        e.we = (op == 5'd0 || op == 5'd5) && r != 5'd0;
        if (op == 5'd8) begin
            e.data = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
            e.we = r != 5'd0;
        end
        if (op == 5'd7) begin
            ref_mem[a] = sd;
            e.we = 1'b0;
            e.chk_data = 1'b0;
        end
        if (tmo) begin
            e.we = 1'b0;
            e.chk_data = 1'b0;
        end
        sb.push_back(e);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("drain_empty", 32'(sb.size()), 0);
    endtask

    // memory responder: answers after a chosen number of BUSY cycles, toggles ready randomly while idle
    always @(negedge clock) begin
        int          waited;
        int          lat;
        bit          in_txn;
        logic [11:0] ra;
        if (dmem_bus.req && !reset) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                waited = 0;
                lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 4));
            end
            if (waited >= lat) begin
                ra = dmem_bus.addr;
                dmem_bus.ready = 1'b1;
                dmem_bus.rdata = mem.exists(ra) ? mem[ra] : init_val(ra);
                if (dmem_bus.we) mem[ra] = dmem_bus.wdata;
                in_txn = 1'b0;
            end else begin
                dmem_bus.ready = 1'b0;
                dmem_bus.rdata = $urandom;
                waited++;
            end
        end else begin
            in_txn = 1'b0;
            dmem_bus.ready = $urandom_range(0, 3) == 0;
            dmem_bus.rdata = $urandom;
        end
    end

    // monitor: every retirement is matched against the oldest expected entry
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wb_unexpected: got wb_valid with wb_rd %0d, want no retirement", wb_rd);
                end else begin
                    e = sb.pop_front();
                    check("wb_we", 32'(wb_we), 32'(e.we));
                    check("wb_rd", 32'(wb_rd), 32'(e.rd));
                    check("wb_mem_error", 32'(mem_error), 32'(e.err));
                    if (e.chk_data) check("wb_data", wb_data, e.data);
                end
            end else if (mem_error) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mem_error_alone: got 1 without wb_valid, want 0");
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          nwe;
        int          k;
        logic [4:0]  op;
        logic [4:0]  r;
        logic [31:0] a;
        repeat (2) @(negedge clock);
        check_zero("rst_init");
        reset = 1'b0;

        fixed_lat = 0;
        issue(5'd5, 32'h0000_002A, 32'h0, 5'd3, 1'b0);
        n = 0;
        repeat (3) begin
            @(negedge clock);
            n += int'(stall);
        end
        check("addi_stall_cycles", 32'(n), 0);

        mem[12'h010] = 32'hDEAD_BEEF;
        ref_mem[12'h010] = 32'hDEAD_BEEF;
        fixed_lat = 3;
        issue(5'd8, 32'h0000_0010, 32'h0, 5'd9, 1'b0);
        n = 0;
        @(negedge clock);
        while (stall && n < 50) begin
            check("lw_addr", 32'(dmem_bus.addr), 32'h010);
            n++;
            @(negedge clock);
        end
        check("lw_stall_cycles", 32'(n), 4);
        drain();

        fixed_lat = 0;
        issue(5'd7, 32'h0000_00FF, 32'h1234_5678, 5'd4, 1'b0);
        n = 0;
        nwe = 0;
        @(negedge clock);
        while (stall && n < 50) begin
            if (dmem_bus.we) begin
                nwe++;
                check("sw_wdata", dmem_bus.wdata, 32'h1234_5678);
                check("sw_addr", 32'(dmem_bus.addr), 32'h0FF);
            end
            n++;
            @(negedge clock);
        end
        check("sw_we_cycles", 32'(nwe), 1);
        check("sw_mem", mem.exists(12'h0FF) ? mem[12'h0FF] : 32'h0, 32'h1234_5678);
        drain();

        fixed_lat = 20;
        issue(5'd8, 32'h0000_0020, 32'hCAFE_0001, 5'd7, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_zero("rst_busy");
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        fixed_lat = 0;
        idle(4);
        issue(5'd5, 32'h0000_0055, 32'h0, 5'd2, 1'b0);
        drain();

`ifdef MEM_TIMEOUT_EN
        fixed_lat = 100000;
        issue(5'd8, 32'h0000_0030, 32'h0, 5'd5, 1'b1);
        n = 0;
        @(negedge clock);
        while (stall && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("tmo_busy_cycles", 32'(n), 15);
        drain();
`endif

        fixed_lat = -1;
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            op = k < 2 ? 5'd0 : k < 4 ? 5'd5 : k < 6 ? 5'd7 : k < 8 ? 5'd8 : 5'($urandom);
            r = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            a = $urandom;
            if (op == 5'd7 || op == 5'd8) a[11:3] = 9'd0;
            issue(op, a, $urandom, r, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
